// File: rtl/i8228_pkg.sv
// Shared constants for the i8228 bus controller: status bit positions, FSM states, opcodes.
package i8228_pkg;

  localparam int unsigned ST_MEMR  = 7;
  localparam int unsigned ST_INP   = 6;
  localparam int unsigned ST_M1    = 5;
  localparam int unsigned ST_OUT   = 4;
  localparam int unsigned ST_HLTA  = 3;
  localparam int unsigned ST_STACK = 2;
  localparam int unsigned ST_WO_N  = 1;
  localparam int unsigned ST_INTA  = 0;

  localparam int unsigned LVL_W    = 3;
  localparam int unsigned ADDR_W   = 16;

  localparam logic [7:0] RST_BASE = 8'hC7;
  localparam logic [7:0] CALL_OP  = 8'hCD;
  localparam logic [7:0] RST7     = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B0   = 2'd1,
    B1   = 2'd2,
    B2   = 2'd3
  } state_t;

endpackage

// File: rtl/i8228_prio_enc8.sv
// 8-to-3 priority encoder; bit 7 wins, and an idle request bus reports level 7.
module prio_enc8
  import i8228_pkg::*;
(
  input  logic [7:0]       irq,
  output logic [LVL_W-1:0] level_c
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    level_c = LVL_W'(7);
    for (int i = 0; i < 8; i++) begin
      if (irq[i]) level_c = LVL_W'(i);
    end
  end

endmodule

// File: rtl/i8228.sv
// 8080 system controller: status latch, bus strobe decode and interrupt vector sequencer.
module i8228
  import i8228_pkg::*;
#(
  parameter int unsigned       VEC_MODE  = 0,
  parameter logic [ADDR_W-1:0] CALL_BASE = 16'h0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       sync,
  input  logic [7:0] status_in,
  input  logic       rd,
  input  logic       wr_n,
  input  logic       inte,
  input  logic [7:0] irq,
  output logic [7:0] status,
  output logic       memr,
  output logic       memw,
  output logic       ior,
  output logic       iow,
  output logic       inta,
  output logic [7:0] vec_data,
  output logic       intr,
  output logic       hlta
);

  localparam bit CALL_MODE = (VEC_MODE == 1);

  state_t            state_q, state_d;
  logic [LVL_W-1:0]  n_q, n_d;
  logic [LVL_W-1:0]  level_c;
  logic [7:0]        status_q;
  logic              intr_q, intr_d;
  logic [ADDR_W-1:0] call_addr;
  logic              unused_ce;

  // ce is part of the CPU-side interface only; nothing here is qualified by it.
  assign unused_ce = ce;

  prio_enc8 u_prio (
    .irq     (irq),
    .level_c (level_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_q <= 8'h00;
      state_q  <= IDLE;
      n_q      <= '0;
      intr_q   <= 1'b0;
    end else begin
      if (sync) status_q <= status_in;
      state_q <= state_d;
      n_q     <= n_d;
      intr_q  <= intr_d;
    end
  end

  // Acknowledge sequencer; any sync that is not an INTA read abandons the sequence.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    unique case (state_q)
      IDLE: if (sync && status_in[ST_INTA] && status_in[ST_M1]) begin
        n_d     = level_c;
        state_d = B0;
      end
      B0:   if (sync) state_d = (CALL_MODE && status_in[ST_INTA]) ? B1 : IDLE;
      B1:   if (sync) state_d = status_in[ST_INTA] ? B2 : IDLE;
      B2:   if (sync) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Looking at the next state drops intr on the same edge that enters B0.
  assign intr_d    = inte & (|irq) & (state_d == IDLE);
  assign call_addr = CALL_BASE + ADDR_W'({n_q, 3'b000});

  always_comb begin
    vec_data = RST7;
    unique case (state_q)
      IDLE: vec_data = RST7;
      B0:   vec_data = CALL_MODE ? CALL_OP : (RST_BASE | {2'b00, n_q, 3'b000});
      B1:   vec_data = call_addr[7:0];
      B2:   vec_data = call_addr[15:8];
      default: vec_data = RST7;
    endcase
  end

  assign status = status_q;
  assign memr   = rd & status_q[ST_MEMR];
  assign ior    = rd & status_q[ST_INP];
  assign inta   = rd & status_q[ST_INTA];
  assign memw   = ~wr_n & ~status_q[ST_OUT];
  assign iow    = ~wr_n & status_q[ST_OUT];
  assign hlta   = status_q[ST_HLTA];
  assign intr   = intr_q;

endmodule
